// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates one fetch port and an in-order load/store FIFO onto a single backing-memory port.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   if_valid_in, if_addr_in            fetch request (one outstanding, held in a holding register)
//   if_data_out, if_ready_out          fetched word, one-cycle completion pulse
//   if_stall_out                       fetch port busy
//   d_valid_in, d_rw_in, d_addr_in,
//   d_data_in, d_id_in                 load/store request pushed into a D_DEPTH-entry FIFO
//   d_data_out, d_id_out, d_ready_out  completion of the oldest data request (data 0 for stores)
//   d_stall_out                        data FIFO full
//   mem_req_out, mem_rw_out,
//   mem_addr_out, mem_wdata_out        backing-memory request, held until mem_ack_in
//   mem_rdata_in, mem_ack_in           backing-memory response
//   error_out                          sticky acknowledge-timeout flag
module memory_arbiter #(
  parameter int D_DEPTH     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid_in,
  input  logic [31:0] if_addr_in,
  output logic [31:0] if_data_out,
  output logic        if_ready_out,
  output logic        if_stall_out,
  input  logic        d_valid_in,
  input  logic        d_rw_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_data_in,
  input  logic [3:0]  d_id_in,
  output logic [31:0] d_data_out,
  output logic [3:0]  d_id_out,
  output logic        d_ready_out,
  output logic        d_stall_out,
  output logic        mem_req_out,
  output logic        mem_rw_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic        error_out
);
  localparam int AW = $clog2(D_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] TO = 8'(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;
  state_t state;
  logic          if_pend;
  logic [31:0]   if_addr;
  logic          q_rw   [D_DEPTH];
  logic [31:0]   q_addr [D_DEPTH];
  logic [31:0]   q_data [D_DEPTH];
  logic [3:0]    q_id   [D_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          last_d;
  logic [7:0]    wait_cnt;
  logic          if_acc, d_acc, pop, f_pend, d_pend, busy;
  assign if_stall_out = if_pend;
  assign d_stall_out  = count == CW'(D_DEPTH);
  assign if_acc       = if_valid_in && !if_pend;
  assign d_acc        = d_valid_in && !d_stall_out;
  // d_ready_out is only high in RESP, so it doubles as "the granted side was data"
  assign pop          = state == RESP && d_ready_out;
  // requests arriving on this edge count as pending so service starts one cycle after accept
  assign f_pend       = if_pend || if_valid_in;
  assign d_pend       = count != '0 || d_acc;
  assign busy         = state == I_BUSY || state == D_BUSY;
  // memory-side outputs decode straight from state/holding registers: stable while waiting, and
  // mem_req_out falls the instant the asynchronous reset hits the state register
  assign mem_req_out   = busy;
  assign mem_rw_out    = state == D_BUSY && q_rw[rd_ptr];
  assign mem_addr_out  = state == I_BUSY ? if_addr : state == D_BUSY ? q_addr[rd_ptr] : '0;
  assign mem_wdata_out = mem_rw_out ? q_data[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (d_acc) begin
      q_rw[wr_ptr]   <= d_rw_in;
      q_addr[wr_ptr] <= d_addr_in;
      q_data[wr_ptr] <= d_data_in;
      q_id[wr_ptr]   <= d_id_in;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      if_pend      <= 1'b0;
      if_addr      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      last_d       <= 1'b1;
      wait_cnt     <= '0;
      error_out    <= 1'b0;
      if_ready_out <= 1'b0;
      if_data_out  <= '0;
      d_ready_out  <= 1'b0;
      d_data_out   <= '0;
      d_id_out     <= '0;
    end else begin
      if (if_acc) begin
        if_pend <= 1'b1;
        if_addr <= if_addr_in;
      end
      if (d_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(d_acc) - CW'(pop);
      // saturating count of consecutive unacknowledged request cycles
      if (!busy || mem_ack_in) wait_cnt <= '0;
      else if (wait_cnt != TO) wait_cnt <= wait_cnt + 8'd1;
      if (busy && !mem_ack_in && wait_cnt == TO - 8'd1) error_out <= 1'b1;
      if_ready_out <= 1'b0;
      d_ready_out  <= 1'b0;
      case (state)
        IDLE:   state <= f_pend && (!d_pend || last_d) ? I_BUSY : d_pend ? D_BUSY : IDLE;
        I_BUSY: if (mem_ack_in) begin
          state        <= RESP;
          if_ready_out <= 1'b1;
          if_data_out  <= mem_rdata_in;
        end
        D_BUSY: if (mem_ack_in) begin
          state       <= RESP;
          d_ready_out <= 1'b1;
          d_data_out  <= q_rw[rd_ptr] ? '0 : mem_rdata_in;
          d_id_out    <= q_id[rd_ptr];
        end
        RESP: begin
          state  <= IDLE;
          last_d <= d_ready_out;
          if (!d_ready_out) if_pend <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized + directed bench for memory_arbiter against a queue-based reference model.
module tb_memory_arbiter;
  localparam int DEPTH = 4;
  localparam int TO    = 255;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_valid_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic [31:0] if_data_out;
  logic        if_ready_out, if_stall_out;
  logic        d_valid_in = 1'b0, d_rw_in = 1'b0;
  logic [31:0] d_addr_in = '0, d_data_in = '0;
  logic [3:0]  d_id_in = '0;
  logic [31:0] d_data_out;
  logic [3:0]  d_id_out;
  logic        d_ready_out, d_stall_out;
  logic        mem_req_out, mem_rw_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [31:0] mem_rdata_in = '0;
  logic        mem_ack_in = 1'b0;
  logic        error_out;
  memory_arbiter #(.D_DEPTH(DEPTH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_in(if_valid_in), .if_addr_in(if_addr_in), .if_data_out(if_data_out),
    .if_ready_out(if_ready_out), .if_stall_out(if_stall_out),
    .d_valid_in(d_valid_in), .d_rw_in(d_rw_in), .d_addr_in(d_addr_in), .d_data_in(d_data_in),
    .d_id_in(d_id_in), .d_data_out(d_data_out), .d_id_out(d_id_out), .d_ready_out(d_ready_out),
    .d_stall_out(d_stall_out), .mem_req_out(mem_req_out), .mem_rw_out(mem_rw_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in),
    .mem_ack_in(mem_ack_in), .error_out(error_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  id;
  } dreq_t;
  // reference model: pending fetch, queue of data requests, which side memory is serving (0 none, 1 fetch, 2 data)
  dreq_t       dq[$];
  bit          fv;
  logic [31:0] fa;
  int          srv;
  bit          resp, resp_d, last_d, err, acc_d_last;
  logic [31:0] exp_rd;
  logic [3:0]  exp_id;
  int          waitc;
  int          total = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic void m_clear();
    dq.delete();
    fv = 0; fa = '0; srv = 0; resp = 0; resp_d = 0; last_d = 1; waitc = 0; err = 0; acc_d_last = 0;
  endfunction
  // advance the model across one rising edge using the inputs presented before it
  function automatic void m_step();
    bit ai, ad, fp, dp;
    dreq_t r;
    if (!rst_n) begin
      m_clear();
      return;
    end
    ai = if_valid_in && !fv;
    ad = d_valid_in && dq.size() < DEPTH;
    acc_d_last = ad;
    if (resp) begin
      if (resp_d) dq.delete(0);
      else fv = 0;
      last_d = resp_d;
      resp = 0;
    end else if (srv != 0) begin
      if (mem_ack_in) begin
        resp = 1;
        resp_d = srv == 2;
        exp_rd = srv == 1 ? mem_rdata_in : (dq[0].rw ? 32'h0 : mem_rdata_in);
        if (srv == 2) exp_id = dq[0].id;
        srv = 0;
        waitc = 0;
      end else begin
        waitc++;
        if (waitc == TO) err = 1;
      end
    end else begin
      fp = fv || ai;
      dp = dq.size() > 0 || ad;
      srv = fp && (!dp || last_d) ? 1 : dp ? 2 : 0;
    end
    if (ai) begin
      fv = 1;
      fa = if_addr_in;
    end
    if (ad) begin
      r.rw = d_rw_in; r.a = d_addr_in; r.d = d_data_in; r.id = d_id_in;
      dq.push_back(r);
    end
  endfunction
  task automatic cmp();
    chk("mem_req", 32'(mem_req_out), 32'(srv != 0));
    chk("mem_addr", mem_addr_out, srv == 1 ? fa : srv == 2 ? dq[0].a : 32'h0);
    chk("mem_rw", 32'(mem_rw_out), 32'(srv == 2 && dq[0].rw));
    chk("mem_wdata", mem_wdata_out, (srv == 2 && dq[0].rw) ? dq[0].d : 32'h0);
    chk("if_stall", 32'(if_stall_out), 32'(fv));
    chk("d_stall", 32'(d_stall_out), 32'(dq.size() == DEPTH));
    chk("if_ready", 32'(if_ready_out), 32'(resp && !resp_d));
    chk("d_ready", 32'(d_ready_out), 32'(resp && resp_d));
    chk("error", 32'(error_out), 32'(err));
    if (resp && !resp_d) chk("if_data", if_data_out, exp_rd);
    if (resp && resp_d) begin
      chk("d_data", d_data_out, exp_rd);
      chk("d_id", 32'(d_id_out), 32'(exp_id));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    cmp();
  endtask
  task automatic do_reset();
    rst_n = 0; if_valid_in = 0; d_valid_in = 0; mem_ack_in = 0;
    #1;
    m_clear();
    cmp();
    tick();
    tick();
    rst_n = 1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0]  got_id[$];
    logic [31:0] got_dat[$];
    int idx, n;
    m_clear();
    #2;
    do_reset();
    chk("reset_mem_req", 32'(mem_req_out), 0);
    chk("reset_mem_addr", mem_addr_out, 0);
    chk("reset_if_ready", 32'(if_ready_out), 0);
    chk("reset_d_ready", 32'(d_ready_out), 0);
    chk("reset_if_stall", 32'(if_stall_out), 0);
    chk("reset_d_stall", 32'(d_stall_out), 0);
    chk("reset_error", 32'(error_out), 0);
    chk("reset_if_data", if_data_out, 0);
    chk("reset_d_data", d_data_out, 0);
    // tie right after reset: fetch wins, load id 5 follows
    if_valid_in = 1; if_addr_in = 32'h80;
    d_valid_in = 1; d_rw_in = 0; d_addr_in = 32'h100; d_id_in = 4'd5;
    tick();
    if_valid_in = 0; d_valid_in = 0;
    chk("tie_first_addr", mem_addr_out, 32'h80);
    mem_ack_in = 1; mem_rdata_in = 32'h1111_1111;
    tick();
    mem_ack_in = 0;
    chk("tie_if_ready", 32'(if_ready_out), 1);
    chk("tie_d_ready_low", 32'(d_ready_out), 0);
    tick();
    tick();
    chk("tie_second_addr", mem_addr_out, 32'h100);
    mem_ack_in = 1; mem_rdata_in = 32'h2222_2222;
    tick();
    mem_ack_in = 0;
    chk("tie_d_ready", 32'(d_ready_out), 1);
    chk("tie_d_id", 32'(d_id_out), 5);
    chk("tie_d_data", d_data_out, 32'h2222_2222);
    // fetch only: accept at edge 0, ack in cycle 3, ready in cycle 4
    do_reset();
    if_valid_in = 1; if_addr_in = 32'h40;
    tick();
    if_valid_in = 0;
    chk("fetch_req_c1", 32'(mem_req_out), 1);
    chk("fetch_addr_c1", mem_addr_out, 32'h40);
    tick();
    chk("fetch_req_c2", 32'(mem_req_out), 1);
    tick();
    chk("fetch_req_c3", 32'(mem_req_out), 1);
    mem_ack_in = 1; mem_rdata_in = 32'hDEAD_BEEF;
    tick();
    mem_ack_in = 0;
    chk("fetch_ready_c4", 32'(if_ready_out), 1);
    chk("fetch_data_c4", if_data_out, 32'hDEAD_BEEF);
    chk("fetch_req_c4", 32'(mem_req_out), 0);
    // fill: five back-to-back data requests with no ack
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      d_valid_in = 1; d_rw_in = 1'(k % 2); d_addr_in = 32'(k * 16); d_data_in = 32'(k * 32'h101); d_id_in = 4'(k);
      tick();
      chk("fill_stall", 32'(d_stall_out), 32'(k >= 4));
    end
    d_valid_in = 0;
    got_id.delete();
    n = 0;
    while ((dq.size() > 0 || srv != 0 || resp) && n < 100) begin
      mem_ack_in = 1; mem_rdata_in = $urandom;
      tick();
      n++;
      if (d_ready_out) got_id.push_back(d_id_out);
    end
    mem_ack_in = 0;
    chk("fill_completions", 32'(got_id.size()), 4);
    for (int i = 0; i < got_id.size(); i++) chk("fill_id", 32'(got_id[i]), 32'(i + 1));
    // order and pointer wrap: six mixed requests through the four-entry FIFO
    do_reset();
    got_id.delete();
    got_dat.delete();
    idx = 0;
    n = 0;
    while (got_id.size() < 6 && n < 300) begin
      d_valid_in = idx < 6; d_rw_in = 1'(idx % 2 == 0); d_addr_in = 32'(idx * 4 + 32'h400);
      d_data_in = 32'hC0DE_0000 + 32'(idx); d_id_in = 4'(idx + 1);
      mem_ack_in = 1; mem_rdata_in = 32'hA000_0000 | 32'($urandom_range(1, 65535));
      tick();
      n++;
      if (acc_d_last) idx++;
      if (d_ready_out) begin
        got_id.push_back(d_id_out);
        got_dat.push_back(d_data_out);
      end
    end
    d_valid_in = 0; mem_ack_in = 0;
    chk("order_count", 32'(got_id.size()), 6);
    for (int i = 0; i < got_id.size(); i++) begin
      chk("order_id", 32'(got_id[i]), 32'(i + 1));
      if (i % 2 == 0) chk("order_store_data", got_dat[i], 0);
    end
    // timeout: fetch never acknowledged
    do_reset();
    if_valid_in = 1; if_addr_in = 32'h200;
    tick();
    if_valid_in = 0;
    repeat (254) tick();
    chk("timeout_early", 32'(error_out), 0);
    tick();
    chk("timeout_set", 32'(error_out), 1);
    chk("timeout_still_req", 32'(mem_req_out), 1);
    tick();
    rst_n = 0;
    #1;
    chk("async_rst_req", 32'(mem_req_out), 0);
    chk("async_rst_error", 32'(error_out), 0);
    chk("async_rst_if_stall", 32'(if_stall_out), 0);
    chk("async_rst_addr", mem_addr_out, 0);
    do_reset();
    // randomized traffic with spurious acks and rare resets
    for (int c = 0; c < 3000; c++) begin
      if_valid_in = $urandom_range(0, 2) == 0; if_addr_in = $urandom;
      d_valid_in = $urandom_range(0, 2) == 0; d_rw_in = 1'($urandom_range(0, 1));
      d_addr_in = $urandom; d_data_in = $urandom; d_id_in = 4'($urandom_range(0, 15));
      mem_ack_in = srv != 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 7) == 0;
      mem_rdata_in = $urandom;
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
